// File: rtl/vga_scaled_controller_pkg.sv
// Shared definitions for the scaled VGA controller: default 640x480@60 timing,
// the decoded flag bundle carried down the alignment pipeline, and a width helper.
package vga_scaled_controller_pkg;

    // 640x480@60 timing with a 25 MHz pixel clock
    localparam int DEF_HACTIVE = 640;
    localparam int DEF_HFRONT  = 16;
    localparam int DEF_HSYNC   = 96;
    localparam int DEF_HBACK   = 48;
    localparam int DEF_VACTIVE = 480;
    localparam int DEF_VFRONT  = 10;
    localparam int DEF_VSYNC   = 2;
    localparam int DEF_VBACK   = 33;
    localparam int DEF_HTOTAL  = DEF_HACTIVE + DEF_HFRONT + DEF_HSYNC + DEF_HBACK;
    localparam int DEF_VTOTAL  = DEF_VACTIVE + DEF_VFRONT + DEF_VSYNC + DEF_VBACK;

    localparam int DEF_RGB_W   = 3;
    localparam int DEF_ADDR_W  = 16;

    // Per-position flags decoded from the raster counters
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic frame;
        logic line;
    } flags_t;

    localparam int FLAGS_W = $bits(flags_t);

    // Counter width for values 0..n-1, never zero bits wide
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_scaled_controller_if.sv
// Framebuffer read port: the controller issues address/request, the pixel
// source answers with colour after a fixed latency.
interface vga_scaled_controller_if
    import vga_scaled_controller_pkg::*;
#(
    parameter int RGB_W  = DEF_RGB_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();
    logic [ADDR_W-1:0] pixel_address;
    logic              pixel_req;
    logic [RGB_W-1:0]  pixel_rgb;

    modport master (output pixel_address, output pixel_req, input pixel_rgb);
    modport slave  (input pixel_address, input pixel_req, output pixel_rgb);
endinterface

// File: rtl/vga_scaled_controller_delay_line.sv
// Reset-clearable shift register; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift one position per clock; reset empties every stage
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_scaled_controller.sv
// Configurable VGA timing generator with integer pixel replication. The
// framebuffer address is built incrementally (no multiplier) and all outputs
// leave FETCH_LATENCY+2 cycles after the raster position they describe.
module vga_scaled_controller
    import vga_scaled_controller_pkg::*;
#(
    parameter int HACTIVE       = DEF_HACTIVE,
    parameter int HFRONT        = DEF_HFRONT,
    parameter int HSYNC         = DEF_HSYNC,
    parameter int HBACK         = DEF_HBACK,
    parameter int VACTIVE       = DEF_VACTIVE,
    parameter int VFRONT        = DEF_VFRONT,
    parameter int VSYNC         = DEF_VSYNC,
    parameter int VBACK         = DEF_VBACK,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    parameter int SCALE         = 4,
    parameter int RGB_W         = DEF_RGB_W,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int FETCH_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    vga_scaled_controller_if.master fb,
    output logic [RGB_W-1:0]        vga_rgb,
    output logic                    vga_hsync,
    output logic                    vga_vsync,
    output logic                    frame_start,
    output logic                    line_start
);
    localparam int HTOTAL = HACTIVE + HFRONT + HSYNC + HBACK;
    localparam int VTOTAL = VACTIVE + VFRONT + VSYNC + VBACK;
    localparam int FB_W   = HACTIVE / SCALE;
    localparam int HW     = cnt_width(HTOTAL);
    localparam int VW     = cnt_width(VTOTAL);
    localparam int RW     = cnt_width(SCALE);

    localparam logic [HW-1:0] H_ACT      = HW'(HACTIVE);
    localparam logic [HW-1:0] H_SYNC_ON  = HW'(HACTIVE + HFRONT);
    localparam logic [HW-1:0] H_SYNC_OFF = HW'(HACTIVE + HFRONT + HSYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(VACTIVE);
    localparam logic [VW-1:0] V_SYNC_ON  = VW'(VACTIVE + VFRONT);
    localparam logic [VW-1:0] V_SYNC_OFF = VW'(VACTIVE + VFRONT + VSYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W);

    logic [HW-1:0]     h_count_p0;
    logic [VW-1:0]     v_count_p0;
    logic [RW-1:0]     h_rep_p0, v_rep_p0;
    logic [ADDR_W-1:0] col_p0, line_base_p0, address_p0;
    logic              active_p0, line_end_p0;
    flags_t            flags_p0, flags_dly;
    logic [ADDR_W-1:0] address_p1;
    logic              req_p1;

    assign line_end_p0 = (h_count_p0 == H_LAST);
    assign active_p0   = (h_count_p0 < H_ACT) && (v_count_p0 < V_ACT);
    assign address_p0  = line_base_p0 + col_p0;

    assign flags_p0.active = active_p0;
    assign flags_p0.hs     = (h_count_p0 >= H_SYNC_ON) && (h_count_p0 < H_SYNC_OFF);
    assign flags_p0.vs     = (v_count_p0 >= V_SYNC_ON) && (v_count_p0 < V_SYNC_OFF);
    assign flags_p0.frame  = (h_count_p0 == '0) && (v_count_p0 == '0);
    assign flags_p0.line   = (h_count_p0 == '0) && (v_count_p0 < V_ACT);

    // ---- Stage 0: raster position ----
    // Horizontal counter wraps every line and steps the vertical counter
    always_ff @(posedge clock) begin
        if (reset) begin
            h_count_p0 <= '0;
            v_count_p0 <= '0;
        end else if (line_end_p0) begin
            h_count_p0 <= '0;
            v_count_p0 <= (v_count_p0 == V_LAST) ? '0 : v_count_p0 + VW'(1);
        end else begin
            h_count_p0 <= h_count_p0 + HW'(1);
        end
    end

    // Replication counters: column advances every SCALE active pixels, line
    // base advances by one framebuffer row every SCALE active lines
    always_ff @(posedge clock) begin
        if (reset) begin
            h_rep_p0     <= '0;
            col_p0       <= '0;
            v_rep_p0     <= '0;
            line_base_p0 <= '0;
        end else begin
            if (active_p0) begin
                if (h_rep_p0 == REP_LAST) begin
                    h_rep_p0 <= '0;
                    col_p0   <= col_p0 + ADDR_W'(1);
                end else begin
                    h_rep_p0 <= h_rep_p0 + RW'(1);
                end
            end else begin
                h_rep_p0 <= '0;
                col_p0   <= '0;
            end
            if (line_end_p0) begin
                if (v_count_p0 == V_LAST) begin
                    v_rep_p0     <= '0;
                    line_base_p0 <= '0;
                end else if (v_count_p0 < V_ACT) begin
                    if (v_rep_p0 == REP_LAST) begin
                        v_rep_p0     <= '0;
                        line_base_p0 <= line_base_p0 + LINE_STEP;
                    end else begin
                        v_rep_p0 <= v_rep_p0 + RW'(1);
                    end
                end
            end
        end
    end

    // ---- Stage 1: framebuffer request ----
    // Blanking positions never issue an address, so nothing out of range escapes
    always_ff @(posedge clock) begin
        if (reset) begin
            address_p1 <= '0;
            req_p1     <= 1'b0;
        end else begin
            address_p1 <= active_p0 ? address_p0 : '0;
            req_p1     <= active_p0;
        end
    end

    assign fb.pixel_address = address_p1;
    assign fb.pixel_req     = req_p1;

    // Flags wait out the request stage plus the pixel source latency
    vga_delay_line #(
        .WIDTH (FLAGS_W),
        .DEPTH (1 + FETCH_LATENCY)
    ) u_flag_delay (
        .clock (clock),
        .reset (reset),
        .din   (flags_p0),
        .dout  (flags_dly)
    );

    // ---- Output stage: aligned pins ----
    // Colour is forced to black whenever the delayed position is blanking
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_rgb     <= '0;
            vga_hsync   <= ~HSYNC_POL;
            vga_vsync   <= ~VSYNC_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            vga_rgb     <= flags_dly.active ? fb.pixel_rgb : '0;
            vga_hsync   <= flags_dly.hs ? HSYNC_POL : ~HSYNC_POL;
            vga_vsync   <= flags_dly.vs ? VSYNC_POL : ~VSYNC_POL;
            frame_start <= flags_dly.frame;
            line_start  <= flags_dly.line;
        end
    end

endmodule

// File: tb/tb_vga_scaled_controller.sv
// Bench for vga_scaled_controller: three instances (default timing, a small
// randomised raster, and an unscaled zero-latency high-polarity variant) are
// compared every cycle against a div/mod raster model.
module tb_vga_scaled_controller;
    import vga_scaled_controller_pkg::*;

    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb, s, lat;
        bit polh, polv;
    } timing_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    int checks = 0;
    int failures = 0;

    timing_t t0, t1, t2;
    logic [2:0] mem1 [48];
    logic [2:0] mem2 [5120];

    logic [2:0] rgb0, rgb1, rgb2;
    logic hs0, vs0, fs0, ls0, hs1, vs1, fs1, ls1, hs2, vs2, fs2, ls2;
    logic [26:0] obs0, obs1, obs2;

    vga_scaled_controller_if #(.RGB_W(3), .ADDR_W(16)) fb0 ();
    vga_scaled_controller_if #(.RGB_W(3), .ADDR_W(8))  fb1 ();
    vga_scaled_controller_if #(.RGB_W(3), .ADDR_W(19)) fb2 ();

    vga_scaled_controller u_dut0 (
        .clock(clock), .reset(rst0), .fb(fb0.master), .vga_rgb(rgb0),
        .vga_hsync(hs0), .vga_vsync(vs0), .frame_start(fs0), .line_start(ls0));

    vga_scaled_controller #(
        .HACTIVE(32), .HFRONT(4), .HSYNC(6), .HBACK(6),
        .VACTIVE(24), .VFRONT(2), .VSYNC(2), .VBACK(3),
        .SCALE(4), .ADDR_W(8), .FETCH_LATENCY(1)
    ) u_dut1 (
        .clock(clock), .reset(rst1), .fb(fb1.master), .vga_rgb(rgb1),
        .vga_hsync(hs1), .vga_vsync(vs1), .frame_start(fs1), .line_start(ls1));

    vga_scaled_controller #(
        .VACTIVE(8), .VFRONT(2), .VSYNC(2), .VBACK(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .SCALE(1), .ADDR_W(19), .FETCH_LATENCY(0)
    ) u_dut2 (
        .clock(clock), .reset(rst2), .fb(fb2.master), .vga_rgb(rgb2),
        .vga_hsync(hs2), .vga_vsync(vs2), .frame_start(fs2), .line_start(ls2));

    // Pixel sources: registered RAMs for latency 1, combinational for latency 0.
    // They drive all-ones when no request is pending.
    always @(posedge clock) fb0.pixel_rgb <= fb0.pixel_req ? fb0.pixel_address[2:0] : 3'b111;
    always @(posedge clock) fb1.pixel_rgb <= fb1.pixel_req ? mem1[int'(fb1.pixel_address) % 48] : 3'b111;
    assign fb2.pixel_rgb = fb2.pixel_req ? mem2[int'(fb2.pixel_address) % 5120] : 3'b111;

    assign obs0 = {3'b000, fb0.pixel_address, fb0.pixel_req, rgb0, hs0, vs0, fs0, ls0};
    assign obs1 = {11'd0, fb1.pixel_address, fb1.pixel_req, rgb1, hs1, vs1, fs1, ls1};
    assign obs2 = {fb2.pixel_address, fb2.pixel_req, rgb2, hs2, vs2, fs2, ls2};

    // Raster position n cycles after (0,0), from the timing rules directly
    function automatic void decode(input timing_t t, input int n, output bit act,
                                   output int addr, output bit hs, output bit vs,
                                   output bit fr, output bit ln);
        int htot = t.ha + t.hf + t.hsw + t.hb;
        int vtot = t.va + t.vf + t.vsw + t.vb;
        int h = n % htot;
        int v = (n / htot) % vtot;
        act  = (h < t.ha) && (v < t.va);
        addr = act ? (v / t.s) * (t.ha / t.s) + (h / t.s) : 0;
        hs   = (h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hsw);
        vs   = (v >= t.va + t.vf) && (v < t.va + t.vf + t.vsw);
        fr   = (h == 0) && (v == 0);
        ln   = (h == 0) && (v < t.va);
    endfunction

    function automatic logic [2:0] ram_data(input int dut, input int addr);
        if (dut == 0) return 3'(addr & 7);
        else if (dut == 1) return mem1[addr % 48];
        else return mem2[addr % 5120];
    endfunction

    // Expected output vector in the cycle p cycles after reset release
    function automatic logic [26:0] expect_at(input timing_t t, input int dut, input int p);
        bit act, hs, vs, fr, ln;
        int addr;
        logic [18:0] e_addr = '0;
        logic e_req = 1'b0;
        logic [2:0] e_rgb = 3'b000;
        logic e_hs = !t.polh, e_vs = !t.polv, e_fr = 1'b0, e_ln = 1'b0;
        if (p >= 1) begin
            decode(t, p - 1, act, addr, hs, vs, fr, ln);
            e_addr = 19'(addr);
            e_req  = act;
        end
        if (p >= 2 + t.lat) begin
            decode(t, p - 2 - t.lat, act, addr, hs, vs, fr, ln);
            e_rgb = act ? ram_data(dut, addr) : 3'b000;
            e_hs  = hs ? t.polh : !t.polh;
            e_vs  = vs ? t.polv : !t.polv;
            e_fr  = fr;
            e_ln  = ln;
        end
        return {e_addr, e_req, e_rgb, e_hs, e_vs, e_fr, e_ln};
    endfunction

    task automatic test_reset();
        logic [26:0] idle_low  = {19'd0, 1'b0, 3'd0, 4'b1100};
        logic [26:0] idle_high = {19'd0, 1'b0, 3'd0, 4'b0000};
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (obs0 !== idle_low) begin failures++; $display("FAIL reset_dut0 got=%h want=%h", obs0, idle_low); end
        checks++;
        if (obs1 !== idle_low) begin failures++; $display("FAIL reset_dut1 got=%h want=%h", obs1, idle_low); end
        checks++;
        if (obs2 !== idle_high) begin failures++; $display("FAIL reset_dut2_pol got=%h want=%h", obs2, idle_high); end
    endtask

    task automatic test_default_timing();
        int hs_fall = -1, hs_width = 0, prev_line = -1, line_period = -1, local_fail = 0;
        logic [26:0] exp;
        rst0 = 1'b0;
        for (int p = 0; p < 3400; p++) begin
            if (p > 0) @(negedge clock);
            exp = expect_at(t0, 0, p);
            checks++;
            if (obs0 !== exp) begin
                failures++; local_fail++;
                $display("FAIL default_cycle p=%0d got=%h want=%h", p, obs0, exp);
                if (local_fail > 20) break;
            end
            if (hs0 === 1'b0 && hs_fall < 0) hs_fall = p;
            if (hs_fall >= 0 && p < hs_fall + 200 && hs0 === 1'b0) hs_width++;
            if (ls0 === 1'b1) begin
                if (prev_line >= 0 && line_period < 0) line_period = p - prev_line;
                prev_line = p;
            end
            if (p == 5) begin
                checks++;
                if (fb0.pixel_address !== 16'd1) begin failures++; $display("FAIL addr_h4 got=%0d want=1", fb0.pixel_address); end
            end
            if (p == 640) begin
                checks++;
                if (fb0.pixel_address !== 16'd159) begin failures++; $display("FAIL addr_h639 got=%0d want=159", fb0.pixel_address); end
            end
            if (p == 641) begin
                checks++;
                if (fb0.pixel_req !== 1'b0) begin failures++; $display("FAIL req_h640 got=%b want=0", fb0.pixel_req); end
            end
            if (p == 3201) begin
                checks++;
                if (fb0.pixel_address !== 16'd160) begin failures++; $display("FAIL addr_line4 got=%0d want=160", fb0.pixel_address); end
            end
            if (p == 703) begin
                checks++;
                if (rgb0 !== 3'b000 || fb0.pixel_rgb !== 3'b111) begin
                    failures++; $display("FAIL blank_rgb got=%b src=%b want=000", rgb0, fb0.pixel_rgb);
                end
            end
        end
        checks++;
        if (hs_fall != 659) begin failures++; $display("FAIL hsync_start got=%0d want=659", hs_fall); end
        checks++;
        if (hs_width != 96) begin failures++; $display("FAIL hsync_width got=%0d want=96", hs_width); end
        checks++;
        if (line_period != 800) begin failures++; $display("FAIL line_period got=%0d want=800", line_period); end
    endtask

    task automatic test_scale1_latency0();
        int fs_first = -1, fs_period = -1, vs_rise = -1, vs_width = 0, hs_rise = -1, local_fail = 0;
        logic [26:0] exp;
        for (int i = 0; i < 5120; i++) mem2[i] = 3'($urandom_range(0, 7));
        rst2 = 1'b0;
        for (int p = 0; p < 12100; p++) begin
            if (p > 0) @(negedge clock);
            exp = expect_at(t2, 2, p);
            checks++;
            if (obs2 !== exp) begin
                failures++; local_fail++;
                $display("FAIL scale1_cycle p=%0d got=%h want=%h", p, obs2, exp);
                if (local_fail > 20) break;
            end
            if (fs2 === 1'b1) begin
                if (fs_first < 0) fs_first = p;
                else if (fs_period < 0) fs_period = p - fs_first;
            end
            if (vs2 === 1'b1) begin
                if (vs_rise < 0) vs_rise = p;
                vs_width++;
            end
            if (hs2 === 1'b1 && hs_rise < 0) hs_rise = p;
            if (p == 802) begin
                checks++;
                if (fb2.pixel_address !== 19'd641) begin failures++; $display("FAIL addr_1_1 got=%0d want=641", fb2.pixel_address); end
            end
            if (p == 6240) begin
                checks++;
                if (fb2.pixel_address !== 19'd5119) begin failures++; $display("FAIL addr_last got=%0d want=5119", fb2.pixel_address); end
            end
        end
        checks++;
        if (fs_first != 2) begin failures++; $display("FAIL latency0_frame got=%0d want=2", fs_first); end
        checks++;
        if (fs_period != 11200) begin failures++; $display("FAIL frame_period got=%0d want=11200", fs_period); end
        checks++;
        if (hs_rise != 658) begin failures++; $display("FAIL hsync_pol_start got=%0d want=658", hs_rise); end
        checks++;
        if (vs_rise != 8002 || vs_width != 1600) begin
            failures++; $display("FAIL vsync_pol got=%0d/%0d want=8002/1600", vs_rise, vs_width);
        end
    endtask

    task automatic test_random_frames();
        int p = 0, local_fail = 0;
        int rs_a = $urandom_range(200, 1400);
        int rs_b = $urandom_range(2000, 4000);
        logic [26:0] exp;
        logic [26:0] idle_low = {19'd0, 1'b0, 3'd0, 4'b1100};
        for (int i = 0; i < 48; i++) mem1[i] = 3'($urandom_range(0, 7));
        rst1 = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if (k > 0) @(negedge clock);
            exp = expect_at(t1, 1, p);
            checks++;
            if (obs1 !== exp) begin
                failures++; local_fail++;
                $display("FAIL random_cycle k=%0d p=%0d got=%h want=%h", k, p, obs1, exp);
                if (local_fail > 20) break;
            end
            if (p == 1) begin
                checks++;
                if (fb1.pixel_address !== 8'd0 || fb1.pixel_req !== 1'b1) begin
                    failures++; $display("FAIL first_request got=%0d/%b want=0/1", fb1.pixel_address, fb1.pixel_req);
                end
            end
            if (p == 3) begin
                checks++;
                if (fs1 !== 1'b1) begin failures++; $display("FAIL frame_after_release got=%b want=1", fs1); end
            end
            if (k == rs_a || k == rs_b) begin
                rst1 = 1'b1;
                @(negedge clock);
                checks++;
                if (obs1 !== idle_low) begin failures++; $display("FAIL midframe_reset k=%0d got=%h want=%h", k, obs1, idle_low); end
                rst1 = 1'b0;
                p = 0;
            end
            p++;
        end
    endtask

    initial begin
        t0 = '{ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33, s:4, lat:1, polh:1'b0, polv:1'b0};
        t1 = '{ha:32, hf:4, hsw:6, hb:6, va:24, vf:2, vsw:2, vb:3, s:4, lat:1, polh:1'b0, polv:1'b0};
        t2 = '{ha:640, hf:16, hsw:96, hb:48, va:8, vf:2, vsw:2, vb:2, s:1, lat:0, polh:1'b1, polv:1'b1};
        test_reset();
        test_default_timing();
        test_scale1_latency0();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scaled_controller.md
Name: vga_scaled_controller

Overview:
Parametrised, pipelined successor to the current VGA controller. It generates fully configurable horizontal and vertical timing, and incrementally derives a framebuffer address with integer pixel replication (SCALE), so a 160x120 buffer can drive a 640x480 monitor. It compensates a fixed pixel-source read latency so RGB, sync and blanking leave aligned. Sits between the 25 MHz pixel clock domain's pixel generator/framebuffer RAM and the VGA pins.

Parameters:
HACTIVE, 640, visible pixels per line
HFRONT, 16, horizontal front porch (cycles)
HSYNC, 96, horizontal sync pulse width
HBACK, 48, horizontal back porch
VACTIVE, 480, visible lines per frame
VFRONT, 10, vertical front porch (lines)
VSYNC, 2, vertical sync pulse width
VBACK, 33, vertical back porch
HSYNC_POL, 0, asserted level of vga_hsync (0 = active low)
VSYNC_POL, 0, asserted level of vga_vsync
SCALE, 4, pixel replication factor, both axes; must divide HACTIVE and VACTIVE
RGB_W, 3, colour bus width
ADDR_W, 16, pixel_address width; must hold (HACTIVE/SCALE)*(VACTIVE/SCALE)-1
FETCH_LATENCY, 1, cycles from pixel_address to valid pixel_rgb (0 = combinational source)

Ports:
clock  in  1  pixel clock, 25 MHz nominal
reset  in  1  synchronous, active-high
pixel_rgb  in  RGB_W  pixel data from generator/RAM
pixel_address  out  ADDR_W  framebuffer address of the requested pixel
pixel_req  out  1  high when pixel_address is a real (active-area) request
vga_rgb  out  RGB_W  registered colour to DAC; 0 during blanking
vga_hsync  out  1  registered horizontal sync
vga_vsync  out  1  registered vertical sync
frame_start  out  1  one-cycle pulse aligned with vga output of pixel (0,0)
line_start  out  1  one-cycle pulse aligned with vga output of pixel (0,v), every line v

Behaviour:
- Derived: HTOTAL = HACTIVE+HFRONT+HSYNC+HBACK (800); VTOTAL (525); FB_W = HACTIVE/SCALE.
- Counters: h_count 0..HTOTAL-1, then wraps to 0 and advances v_count; v_count 0..VTOTAL-1, then wraps to 0. Stage 0 decode: active = h<HACTIVE && v<VACTIVE; hs = HACTIVE+HFRONT <= h < HACTIVE+HFRONT+HSYNC; vs is analogous on v.
- Address, no multiplier: h_rep (0..SCALE-1) and col advance within active; v_rep and line_base (+FB_W when v_rep wraps at end of an active line; 0 at frame wrap). Address = line_base + col.
- Stage 1: register pixel_address <= active ? address : 0 and pixel_req <= active for the counter position (h,v) at cycle t; both visible in cycle t+1.
- pixel_rgb is sampled in cycle t+1+FETCH_LATENCY.
- Decoded active/hs/vs/frame/line flags pass through a delay line of 1+FETCH_LATENCY stages.
- Output registers: vga_rgb = delayed_active ? pixel_rgb : 0. Sync outputs are driven to POL when asserted, else to ~POL. Total latency from counter position to pins = FETCH_LATENCY+2 cycles, identical for every output.
- Reset, at any time including mid-frame, cleared on the same edge: counters, rep counters, line_base, col and all delay stages. Outputs then read: pixel_address=0, pixel_req=0, vga_rgb=0, vga_hsync=~HSYNC_POL, vga_vsync=~VSYNC_POL, frame_start=line_start=0. After reset deasserts, counting restarts at (0,0).
- Outside the active area, pixel_address=0 and pixel_req=0. No out-of-range address is ever issued.
- pixel_rgb is ignored when the delayed active flag is low.

Decomposition:
- Shared header vga_timing.vh: the 640x480@60 timing constants (the defaults above) plus localparams for HTOTAL and VTOTAL.
- Sub-module vga_delay_line (WIDTH, DEPTH): reset-clearable shift register. Used once for the flag bundle {active, hs, vs, frame, line}. DEPTH=0 is a pass-through.

Test Plan:
- Defaults, release reset at t0 -> vga_hsync low for exactly 96 cycles, starting at t0+656+3. Line period 800 cycles. vga_vsync low during lines 490-491. frame_start period 420000 cycles.
- Defaults address sweep -> pixel_address: h=0..3 gives 0; h=4 gives 1; (639,0) gives 159; line 3 gives 0..159 again; line 4 starts at 160; (639,479) gives 19199. pixel_req low at h=640 and at v=480.
- Model RAM with FETCH_LATENCY=1 returning address[2:0] -> vga_rgb equals the expected pattern, 3 cycles after the counter. vga_rgb=0 through all blanking even when the RAM drives 3'b111.
- SCALE=1, ADDR_W=19, FETCH_LATENCY=0 -> (1,1) gives address 641; last pixel gives 307199. Output latency is 2 cycles.
- Assert reset for 1 cycle at (300,200) -> the next cycle shows all outputs at their reset values. Afterwards, frame_start asserts 3 cycles after release, with first address 0.
- HSYNC_POL=1, VSYNC_POL=1 -> sync pulses are high with the same widths and positions; idle level is low, including during reset.
